// File: rtl/timer_dev_pkg.sv
// Shared definitions for the interval timer: register word offsets, FSM state
// encoding, CTRL field layout and mode codes.
// Imported by timer_dev; holds no logic of its own.
package timer_dev_pkg;

    // Word offsets within the device window (PrAddr[3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // CTRL layout, LSB first: [0] EN, [2:1] MODE, [3] IM
    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_IM_BIT = 3;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only 01 reloads; both 1x codes fall back to one-shot behaviour.
    function automatic logic is_reload(input ctrl_t c);
        return c.mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable interval timer: down-counter with one-shot / auto-reload modes
// and a maskable, level-held (one-shot) or pulsed (auto-reload) interrupt.
// Ports: Clk, Reset (async, active-high), Addr/We/Din bus write side,
//        Dout combinational read data, IRQ registered interrupt request.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [1:0] BASE_SEL = 2'b00  // bridge decode tag, documentation only
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    state_t      r_state;
    ctrl_t       r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pend;
    logic        r_irq;

    logic        w_ctrl_wr;
    logic        w_preset_wr;
    logic        w_cnt_expire;
    logic        w_in_int;
    ctrl_t       w_ctrl_next;
    logic        w_pend_next;

    assign w_ctrl_wr    = We && (Addr == ADDR_CTRL);
    assign w_preset_wr  = We && (Addr == ADDR_PRESET);
    assign w_cnt_expire = (r_state == ST_CNT) && r_ctrl.en && (r_count == 32'd0);
    assign w_in_int     = (r_state == ST_INT);

    // Next CTRL: a bus write always overrides the one-shot self-clear of EN.
    always_comb begin
        w_ctrl_next = r_ctrl;
        if (w_in_int && !is_reload(r_ctrl)) begin
            w_ctrl_next.en = 1'b0;
        end
        if (w_ctrl_wr) begin
            w_ctrl_next = ctrl_t'(Din[3:0]);
        end
    end

    // Next pending: any CTRL write acts as acknowledge and beats a new expiry.
    always_comb begin
        w_pend_next = r_pend;
        if (w_cnt_expire) begin
            w_pend_next = 1'b1;
        end
        if (w_in_int && is_reload(r_ctrl)) begin
            w_pend_next = 1'b0;
        end
        if (w_ctrl_wr) begin
            w_pend_next = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ctrl <= w_ctrl_next;
            r_pend <= w_pend_next;
            r_irq  <= w_pend_next & w_ctrl_next.im;
            if (w_preset_wr) begin
                r_preset <= Din;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_ctrl.en) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    // Disable is checked before expiry; count holds, never wraps.
                    if (!r_ctrl.en) begin
                        r_state <= ST_IDLE;
                    end else if (r_count == 32'd0) begin
                        r_state <= ST_INT;
                    end else begin
                        r_count <= r_count - 32'd1;
                    end
                end
                ST_INT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr)
            ADDR_CTRL:   Dout = {28'd0, r_ctrl};
            ADDR_PRESET: Dout = r_preset;
            ADDR_COUNT:  Dout = r_count;
            default:     Dout = 32'd0;
        endcase
    end

    assign IRQ = r_irq;

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: timeline model of the timer (phase since enable,
// expiry at phase N+3, INT edge at N+4) compared every negedge, plus
// hand-computed literal checks of latency, reload period, ack and reset.
module tb_timer_dev;

    logic        Clk;
    logic        Reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_checks;
    int n_errors;
    bit cmp_on;

    timer_dev #(.BASE_SEL(2'b00)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Addr (Addr),
        .We   (We),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // m_t counts edges since the first edge that saw EN=1 (that edge is t=1).
    // t=2 loads, t in 3..N+2 decrements, t=N+3 expires, t=N+4 is the INT edge.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_pend;
    logic        m_irq;
    bit          m_active;
    longint      m_t;
    longint      m_n;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
            m_pend = 1'b0; m_irq = 1'b0; m_active = 0; m_t = 0; m_n = 0;
        end else begin
            bit en;
            bit rl;
            bit clr_en;
            en = m_ctrl[0];
            rl = (m_ctrl[2:1] == 2'b01);
            clr_en = 0;
            if (!m_active) begin
                if (en) begin
                    m_active = 1;
                    m_t = 1;
                end
            end else begin
                m_t = m_t + 1;
                if (m_t == 2) begin
                    m_n = longint'(m_preset);
                    m_count = m_preset;
                end else if (m_t <= m_n + 3) begin
                    if (!en) m_active = 0;
                    else if (m_t == m_n + 3) m_pend = 1'b1;
                    else m_count = m_count - 32'd1;
                end else begin
                    if (rl) m_pend = 1'b0;
                    else clr_en = 1;
                    m_active = 0;
                end
            end
            if (clr_en) m_ctrl[0] = 1'b0;
            if (We && Addr == 2'd0) begin
                m_ctrl = Din[3:0];
                m_pend = 1'b0;
            end
            if (We && Addr == 2'd1) m_preset = Din;
            m_irq = m_pend & m_ctrl[3];
        end
    end

    function automatic logic [31:0] model_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge Clk) begin
        if (cmp_on) begin
            chk("model_irq", {31'd0, IRQ}, {31'd0, m_irq});
            chk("model_dout", Dout, model_dout(Addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Write registered on the second posedge after the call (edge 0); returns at edge0+1.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge Clk);
        #1;
        We = 1'b1; Addr = a; Din = d;
        @(posedge Clk);
        #1;
        We = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(name, Dout, exp);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cmp_on = 1;
        Reset = 1'b1; We = 1'b0; Addr = 2'd0; Din = 32'd0;
        cyc(2);
        Reset = 1'b0;
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        for (int a = 0; a < 4; a++) rd("rst_dout", 2'(a), 32'd0);

        // One-shot, PRESET=5: IRQ after edge 8, held; EN self-clears
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        cyc(7);
        chk("os_irq_e7", {31'd0, IRQ}, 32'd0);
        cyc(1);
        chk("os_irq_e8", {31'd0, IRQ}, 32'd1);
        cyc(3);
        chk("os_irq_held", {31'd0, IRQ}, 32'd1);
        rd("os_ctrl", 2'd0, 32'h8);
        rd("os_count", 2'd2, 32'd0);
        wr(2'd0, 32'd0);
        chk("os_ack", {31'd0, IRQ}, 32'd0);

        // Auto-reload, PRESET=3: pulses after edges 6, 13, 20
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 21; e++) begin
            cyc(1);
            chk("ar_pulse", {31'd0, IRQ}, {31'd0, (e == 6 || e == 13 || e == 20)});
        end
        wr(2'd0, 32'd0);
        cyc(3);

        // IM=0: pending invisible; CTRL write setting IM acknowledges it
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        cyc(14);
        chk("im0_irq", {31'd0, IRQ}, 32'd0);
        rd("im0_ctrl", 2'd0, 32'd0);
        wr(2'd0, 32'h8);
        chk("im0_ack_irq", {31'd0, IRQ}, 32'd0);
        cyc(3);
        chk("im0_ack_irq2", {31'd0, IRQ}, 32'd0);
        rd("im0_ctrl2", 2'd0, 32'h8);
        wr(2'd0, 32'd0);
        cyc(3);

        // PRESET change + disable mid-count: COUNT holds, re-enable loads new PRESET
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        cyc(7);
        We = 1'b1; Addr = 2'd1; Din = 32'd100;   // registered at edge 8 (COUNT->4)
        cyc(1);
        Addr = 2'd0; Din = 32'd0;                // registered at edge 9 (COUNT->3)
        cyc(1);
        We = 1'b0;
        cyc(3);
        rd("dis_count_hold", 2'd2, 32'd3);
        rd("dis_preset", 2'd1, 32'd100);
        wr(2'd0, 32'h1);
        rd("re_count_e0", 2'd2, 32'd3);
        cyc(1);
        rd("re_count_e1", 2'd2, 32'd3);
        cyc(1);
        rd("re_count_e2", 2'd2, 32'd100);
        wr(2'd0, 32'd0);
        cyc(3);

        // PRESET=0 one-shot: IRQ after edge 3; Addr 2/3 writes ignored
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        cyc(2);
        chk("p0_irq_e2", {31'd0, IRQ}, 32'd0);
        cyc(1);
        chk("p0_irq_e3", {31'd0, IRQ}, 32'd1);
        wr(2'd2, 32'hDEAD);
        wr(2'd3, 32'hBEEF);
        rd("ro_count", 2'd2, 32'd0);
        rd("rsv_read", 2'd3, 32'd0);
        rd("ro_preset", 2'd1, 32'd0);
        chk("p0_irq_held", {31'd0, IRQ}, 32'd1);
        Reset = 1'b1;                            // async: IRQ must drop before any edge
        #1;
        chk("rst_async_irq", {31'd0, IRQ}, 32'd0);
        cyc(1);
        Reset = 1'b0;

        // CTRL write on the CNT->INT edge wins: no pending, CTRL takes Din
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        cyc(4);
        We = 1'b1; Addr = 2'd0; Din = 32'h9;     // registered at edge 5
        cyc(1);
        We = 1'b0;
        chk("sim_irq", {31'd0, IRQ}, 32'd0);
        rd("sim_ctrl", 2'd0, 32'h9);
        cyc(1);
        rd("sim_ctrl_int", 2'd0, 32'h8);
        chk("sim_irq2", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'd0);
        cyc(3);

        // Reset mid-count with COUNT=7
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        cyc(15);
        rd("mid_count7", 2'd2, 32'd7);
        Reset = 1'b1;
        #1;
        chk("mid_rst_irq", {31'd0, IRQ}, 32'd0);
        for (int a = 0; a < 4; a++) rd("mid_rst_dout", 2'(a), 32'd0);
        cyc(1);
        Reset = 1'b0;
        cyc(3);
        rd("mid_idle_count", 2'd2, 32'd0);
        rd("mid_idle_ctrl", 2'd0, 32'd0);

        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
